// File: rtl/sata_txarb.sv
// sata_txarb: two-requester transmit arbiter in front of a SATA link layer.
//
// Grants one of two packet sources (round-robin on contention, s0 first after
// reset), forwards the owner's beats to the link, then waits for the link's
// completion pulse and returns it to the owner as a one-cycle success/failed
// pulse. If the link drops out of ready while a packet is in flight, the rest
// of that packet is drained from the source and reported as failed. If the
// link stays silent for 2^LGTIMEOUT-1 cycles after the last beat, the packet
// is reported as failed and o_timeout pulses.
//
// Ports:
//   i_clk, i_reset          clock; asynchronous active-high reset
//   i_link_ready            link can accept a packet
//   sN_valid/ready/data/last  requester N packet stream (N = 0, 1)
//   sN_success/sN_failed    one-cycle completion pulses to requester N
//   m_valid/ready/data/last packet stream to the link
//   i_success/i_failed      completion pulses from the link
//   o_grant                 one-hot owner, 00 when idle
//   o_timeout               one-cycle pulse when the completion wait expires
module sata_txarb #(
  parameter int unsigned LGTIMEOUT = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_link_ready,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s0_data,
  input  logic        s0_last,
  output logic        s0_success,
  output logic        s0_failed,
  input  logic        s1_valid,
  output logic        s1_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_last,
  output logic        s1_success,
  output logic        s1_failed,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        i_success,
  input  logic        i_failed,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic                 owner;      // 0 = s0, 1 = s1
  logic                 rr_prio;    // requester that wins when both ask
  logic [LGTIMEOUT-1:0] timer;

  logic        own_valid, own_last, own_ready;
  logic [31:0] own_data;
  logic        pick, start, enter_wait;
  logic        pulse_ok, pulse_fail;

  assign own_valid = owner ? s1_valid : s0_valid;
  assign own_last  = owner ? s1_last  : s0_last;
  assign own_data  = owner ? s1_data  : s0_data;

  assign pick  = (s0_valid && s1_valid) ? rr_prio : s1_valid;
  assign start = (state == ST_IDLE) && i_link_ready && (s0_valid || s1_valid);

  always_comb begin
    state_nxt  = state;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    own_ready  = 1'b0;
    pulse_ok   = 1'b0;
    pulse_fail = 1'b0;
    o_timeout  = 1'b0;
    enter_wait = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (!i_link_ready) begin
          // Link lost: behave as DRAIN already in this cycle, so a last beat
          // arriving now terminates the packet immediately.
          own_ready = 1'b1;
          if (own_valid && own_last) begin
            pulse_fail = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          m_valid   = own_valid;
          m_last    = own_last;
          own_ready = m_ready;
          if (own_valid && own_last && m_ready) begin
            state_nxt  = ST_WAIT;
            enter_wait = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        own_ready = 1'b1;
        if (own_valid && own_last) begin
          pulse_fail = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A coincident success and failure is reported as failure.
        if (i_failed) begin
          pulse_fail = 1'b1;
          state_nxt  = ST_IDLE;
        end else if (i_success) begin
          pulse_ok  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timer == '1) begin
          o_timeout  = 1'b1;
          pulse_fail = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s0_ready   = own_ready  && !owner;
  assign s1_ready   = own_ready  &&  owner;
  assign s0_success = pulse_ok   && !owner;
  assign s1_success = pulse_ok   &&  owner;
  assign s0_failed  = pulse_fail && !owner;
  assign s1_failed  = pulse_fail &&  owner;
  assign m_data     = own_data;
  assign o_grant    = (state == ST_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      rr_prio <= 1'b0;
      timer   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        owner   <= pick;
        rr_prio <= !pick;
      end
      if (enter_wait)
        timer <= '0;
      else if (state == ST_WAIT && timer != '1)
        timer <= timer + LGTIMEOUT'(1);
    end
  end

endmodule

// File: tb/tb_sata_txarb.sv
// tb_sata_txarb: self-checking bench for sata_txarb (LGTIMEOUT = 4).
// Sources are fed from queues of random packets; the link side accepts with
// random or fixed m_ready and answers completions after a chosen delay.
// Expected beat streams, grant order and completion counts come from a
// transaction-level model of the arbitration rules.
module tb_sata_txarb;

  localparam int unsigned LGT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset, i_link_ready;
  logic        s0_valid, s0_ready, s0_last, s0_success, s0_failed;
  logic        s1_valid, s1_ready, s1_last, s1_success, s1_failed;
  logic [31:0] s0_data, s1_data, m_data;
  logic        m_valid, m_ready, m_last;
  logic        i_success, i_failed, o_timeout;
  logic [1:0]  o_grant;

  sata_txarb #(.LGTIMEOUT(LGT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_link_ready(i_link_ready),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
    .s0_success(s0_success), .s0_failed(s0_failed),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
    .s1_success(s1_success), .s1_failed(s1_failed),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .i_success(i_success), .i_failed(i_failed),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [32:0] q0[$], q1[$];          // words still to be offered by each source
  logic [32:0] pk0[$], pk1[$];        // every word generated this scenario
  logic [32:0] beats[$], exp_beats[$];
  logic [1:0]  grants[$];
  logic [1:0]  prev_grant;
  int cyc = 0;
  int n_s0s, n_s0f, n_s1s, n_s1f, n_to;
  int cyc_lastbeat, cyc_fail, cyc_to, cyc_lastpop0;
  int resp_mode;   // 0 none, 1 success, 2 failed, 3 both together
  int resp_delay;  // 0 = random 1..6
  int resp_cnt;
  int model_last;  // last granted requester, -1 after reset
  bit en0, en1, rdy_rand;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s0_valid = en0 && (q0.size() != 0);
    s0_data  = (q0.size() != 0) ? q0[0][31:0] : 32'h0;
    s0_last  = (q0.size() != 0) ? q0[0][32] : 1'b0;
    s1_valid = en1 && (q1.size() != 0);
    s1_data  = (q1.size() != 0) ? q1[0][31:0] : 32'h0;
    s1_last  = (q1.size() != 0) ? q1[0][32] : 1'b0;
  endtask

  // One clock: sample at negedge, then update sources/link #1 after posedge.
  task automatic cycle();
    bit f0, f1;
    @(negedge i_clk);
    cyc++;
    f0 = s0_valid && s0_ready;
    f1 = s1_valid && s1_ready;
    chk("one_completion", 64'($countones({s0_success, s0_failed, s1_success, s1_failed}) <= 1), 1);
    chk("grant_onehot", 64'($countones(o_grant) <= 1), 1);
    if (!i_link_ready) chk("mvalid_link_down", m_valid, 0);
    if (m_valid && m_ready) begin
      beats.push_back({m_last, m_data});
      if (m_last) begin
        cyc_lastbeat = cyc;
        if (resp_mode != 0) resp_cnt = (resp_delay == 0) ? $urandom_range(1, 6) : resp_delay;
      end
    end
    if (o_grant != 2'b00 && prev_grant == 2'b00) grants.push_back(o_grant);
    prev_grant = o_grant;
    if (s0_success) n_s0s++;
    if (s1_success) n_s1s++;
    if (s0_failed) n_s0f++;
    if (s1_failed) n_s1f++;
    if (s0_failed || s1_failed) cyc_fail = cyc;
    if (o_timeout) begin n_to++; cyc_to = cyc; end
    @(posedge i_clk);
    #1;
    if (f0) begin
      if (q0[0][32]) cyc_lastpop0 = cyc;
      void'(q0.pop_front());
    end
    if (f1) void'(q1.pop_front());
    i_success = 1'b0;
    i_failed  = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        i_success = (resp_mode == 1) || (resp_mode == 3);
        i_failed  = (resp_mode == 2) || (resp_mode == 3);
      end
    end
    if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk("wait_beats", 64'(beats.size() >= n), 1);
  endtask

  task automatic clear_stats();
    q0.delete(); q1.delete(); pk0.delete(); pk1.delete();
    beats.delete(); exp_beats.delete(); grants.delete();
    n_s0s = 0; n_s0f = 0; n_s1s = 0; n_s1f = 0; n_to = 0;
    cyc_lastbeat = -100; cyc_fail = -200; cyc_to = -300; cyc_lastpop0 = -400;
    resp_cnt = 0;
  endtask

  task automatic gen_pkt(input int src, input int len);
    logic [32:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), 32'($urandom)};
      if (src == 0) begin q0.push_back(w); pk0.push_back(w); end
      else begin q1.push_back(w); pk1.push_back(w); end
    end
  endtask

  task automatic chk_stream();
    chk("beat_count", beats.size(), exp_beats.size());
    for (int i = 0; i < beats.size() && i < exp_beats.size(); i++)
      chk("beat_word", beats[i], exp_beats[i]);
  endtask

  task automatic all_zero();
    chk("rst_grant", o_grant, 0);
    chk("rst_ready", {s0_ready, s1_ready}, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_pulses", {s0_success, s0_failed, s1_success, s1_failed, o_timeout}, 0);
  endtask

  // Both sources request npk packets each; model picks the winner by
  // round-robin from model_last and builds the expected grant/beat order.
  task automatic run_rr(input int npk);
    logic [1:0]  exp_g[$];
    logic [32:0] x;
    int rem0, rem1, w;
    clear_stats();
    resp_mode = 1; resp_delay = 0; rdy_rand = 1;
    for (int p = 0; p < npk; p++) begin
      gen_pkt(0, $urandom_range(1, 4));
      gen_pkt(1, $urandom_range(1, 4));
    end
    rem0 = npk; rem1 = npk;
    for (int k = 0; k < 2 * npk; k++) begin
      if (rem0 > 0 && rem1 > 0) w = (model_last == 0) ? 1 : 0;
      else w = (rem0 > 0) ? 0 : 1;
      exp_g.push_back((w == 1) ? 2'b10 : 2'b01);
      if (w == 0) begin
        do begin x = pk0.pop_front(); exp_beats.push_back(x); end while (!x[32]);
        rem0--;
      end else begin
        do begin x = pk1.pop_front(); exp_beats.push_back(x); end while (!x[32]);
        rem1--;
      end
      model_last = w;
    end
    en0 = 1; en1 = 1; drive();
    run(60 * npk + 40);
    en0 = 0; en1 = 0; drive();
    chk("rr_grant_count", grants.size(), exp_g.size());
    for (int i = 0; i < grants.size() && i < exp_g.size(); i++)
      chk("rr_grant_order", grants[i], exp_g[i]);
    chk_stream();
    chk("rr_s0_success", n_s0s, npk);
    chk("rr_s1_success", n_s1s, npk);
    chk("rr_failed", n_s0f + n_s1f + n_to, 0);
  endtask

  initial begin
    i_reset = 1'b0; i_link_ready = 1'b1; m_ready = 1'b1;
    i_success = 1'b0; i_failed = 1'b0;
    en0 = 0; en1 = 0; rdy_rand = 0;
    resp_mode = 0; resp_delay = 0; model_last = -1; prev_grant = 2'b00;
    clear_stats();
    drive();
    #1 i_reset = 1'b1;
    #1 all_zero();
    run(2);
    i_reset = 1'b0;

    // Single 3-word packet from s0, success 5 cycles after the last beat.
    clear_stats();
    resp_mode = 1; resp_delay = 5;
    gen_pkt(0, 3);
    exp_beats = pk0;
    en0 = 1; drive();
    #2;
    chk("grant_cycle_ready", s0_ready, 0);
    chk("grant_cycle_grant", o_grant, 0);
    cycle();
    chk("grant_registered", o_grant, 2'b01);
    run(20);
    en0 = 0; drive();
    chk_stream();
    chk("s1_grants", grants.size(), 1);
    if (grants.size() > 0) chk("s1_grant_value", grants[0], 2'b01);
    chk("s1_success", n_s0s, 1);
    chk("s1_no_fail", n_s0f + n_s1s + n_s1f + n_to, 0);
    chk("s1_idle_grant", o_grant, 0);
    model_last = 0;

    // Continuous contention: round-robin continues from s0's last grant.
    run_rr(2);

    // No completion: timeout 15 cycles after WAIT entry.
    clear_stats();
    resp_mode = 0; rdy_rand = 1;
    gen_pkt(0, $urandom_range(1, 5));
    exp_beats = pk0;
    en0 = 1; drive();
    run(70);
    en0 = 0; drive();
    chk_stream();
    chk("to_count", n_to, 1);
    chk("to_failed", n_s0f, 1);
    chk("to_delay", 64'(cyc_to - cyc_lastbeat), 16);
    chk("to_with_failed", 64'(cyc_fail), 64'(cyc_to));
    chk("to_no_success", n_s0s + n_s1s + n_s1f, 0);
    model_last = 0;

    // Link drops after beat 2: rest drained, failed on the last word.
    // v=1 has its last word arrive in the very cycle the link drops.
    for (int v = 0; v < 2; v++) begin
      clear_stats();
      i_link_ready = 1'b1; rdy_rand = 0; m_ready = 1'b1;
      resp_mode = 1; resp_delay = 2;
      gen_pkt(0, 4 - v);
      en0 = 1; drive();
      wait_beats(2, 20);
      i_link_ready = 1'b0;
      run(8);
      chk("drop_beats", beats.size(), 2);
      if (beats.size() >= 2) begin
        chk("drop_word0", beats[0], pk0[0]);
        chk("drop_word1", beats[1], pk0[1]);
      end
      chk("drop_consumed", q0.size(), 0);
      chk("drop_failed", n_s0f, 1);
      chk("drop_no_success", n_s0s + n_s1s + n_s1f + n_to, 0);
      chk("drop_fail_on_last", 64'(cyc_fail), 64'(cyc_lastpop0));
      en0 = 0; i_link_ready = 1'b1; drive();
      model_last = 0;
    end

    // s1 packet with coincident success+failed; then completions while idle.
    clear_stats();
    rdy_rand = 1; resp_mode = 3; resp_delay = 3;
    gen_pkt(1, $urandom_range(1, 4));
    exp_beats = pk1;
    en1 = 1; drive();
    run(40);
    en1 = 0; drive();
    chk_stream();
    chk("both_s1_failed", n_s1f, 1);
    chk("both_no_success", n_s1s + n_s0s + n_s0f + n_to, 0);
    model_last = 1;
    resp_mode = 0;
    i_success = 1'b1;
    cycle();
    i_failed = 1'b1;
    cycle();
    run(3);
    chk("idle_completion", n_s0s + n_s0f + n_s1s + n_to, 0);
    chk("idle_s1_failed", n_s1f, 1);

    // Asynchronous reset in the middle of a packet.
    clear_stats();
    rdy_rand = 0; m_ready = 1'b1; resp_mode = 0;
    gen_pkt(0, 6);
    en0 = 1; drive();
    wait_beats(2, 20);
    #2 i_reset = 1'b1;
    #1 all_zero();
    en0 = 0; q0.delete(); drive();
    cycle();
    i_reset = 1'b0;
    clear_stats();
    model_last = -1;
    i_success = 1'b1;
    cycle();
    run(4);
    chk("post_reset_pulses", n_s0s + n_s0f + n_s1s + n_s1f + n_to, 0);
    chk("post_reset_grants", grants.size(), 0);

    // First contention after reset goes to s0.
    run_rr(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
